// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, instruction codes and IR capture value.
// Imported by the TAP state machine and the controller top.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'h0,
        RTI    = 4'h1,
        SEL_DR = 4'h2,
        CAP_DR = 4'h3,
        SH_DR  = 4'h4,
        EX1_DR = 4'h5,
        PA_DR  = 4'h6,
        EX2_DR = 4'h7,
        UPD_DR = 4'h8,
        SEL_IR = 4'h9,
        CAP_IR = 4'hA,
        SH_IR  = 4'hB,
        EX1_IR = 4'hC,
        PA_IR  = 4'hD,
        EX2_IR = 4'hE,
        UPD_IR = 4'hF
    } tap_state_t;

    localparam logic [1:0] IR_EXTEST  = 2'b00;
    localparam logic [1:0] IR_SAMPLE  = 2'b01;
    localparam logic [1:0] IR_BYPASS  = 2'b11;
    localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state register and TMS-driven next-state logic.
// Advances on every TCK rising edge; TRST forces Test-Logic-Reset.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_t state
);

    tap_state_t state_d, state_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:    state_d = TMS ? TLR    : RTI;
            RTI:    state_d = TMS ? SEL_DR : RTI;
            SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
            SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
            EX1_DR: state_d = TMS ? UPD_DR : PA_DR;
            PA_DR:  state_d = TMS ? EX2_DR : PA_DR;
            EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
            UPD_DR: state_d = TMS ? SEL_DR : RTI;
            SEL_IR: state_d = TMS ? TLR    : CAP_IR;
            CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
            SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
            EX1_IR: state_d = TMS ? UPD_IR : PA_IR;
            PA_IR:  state_d = TMS ? EX2_IR : PA_IR;
            EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
            UPD_IR: state_d = TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller: instruction register, instruction decode, falling-edge
// DR strobes, retimed TDO and glitch-free ClockDR gate.
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter int IR_WIDTH = 2
) (
    input  logic TCK,
    input  logic TRST,
    input  logic TMS,
    input  logic TDI,
    input  logic DR_TDO,
    output logic ShiftDR,
    output logic CaptureDR,
    output logic ClockDR,
    output logic UpdateDR,
    output logic Mode,
    output logic MUX_OUT_SEL,
    output logic TDO,
    output logic TDO_EN
);

    localparam logic [IR_WIDTH-1:0] IrExtest  = IR_WIDTH'(IR_EXTEST);
    localparam logic [IR_WIDTH-1:0] IrSample  = IR_WIDTH'(IR_SAMPLE);
    localparam logic [IR_WIDTH-1:0] IrCapture = IR_WIDTH'(IR_CAPTURE);

    tap_state_t state;

    logic [IR_WIDTH-1:0] ir_sh_d, ir_sh_q;
    logic [IR_WIDTH-1:0] ir_q_d, ir_q_q;
    logic shift_dr_d, shift_dr_q;
    logic capture_dr_d, capture_dr_q;
    logic update_dr_d, update_dr_q;
    logic clk_en_d, clk_en_q;
    logic tdo_d, tdo_q;
    logic tdo_en_d, tdo_en_q;
    logic mode, mux_sel;

    jtag_tap_fsm u_fsm (
        .TCK   (TCK),
        .TRST  (TRST),
        .TMS   (TMS),
        .state (state)
    );

    always_comb begin
        ir_sh_d = ir_sh_q;
        if (state == CAP_IR) begin
            ir_sh_d = IrCapture;
        end else if (state == SH_IR) begin
            ir_sh_d = {TDI, ir_sh_q[IR_WIDTH-1:1]};
        end
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_sh_q <= '0;
        end else begin
            ir_sh_q <= ir_sh_d;
        end
    end

    always_comb begin
        ir_q_d = ir_q_q;
        if (state == TLR) begin
            ir_q_d = '1;
        end else if (state == UPD_IR) begin
            ir_q_d = ir_sh_q;
        end
        shift_dr_d   = (state == SH_DR);
        capture_dr_d = (state == CAP_DR);
        update_dr_d  = (state == UPD_DR);
        clk_en_d     = (state == CAP_DR) || (state == SH_DR);
        tdo_en_d     = (state == SH_DR) || (state == SH_IR);
        tdo_d        = tdo_q;
        if (state == SH_IR) begin
            tdo_d = ir_sh_q[0];
        end else if (state == SH_DR) begin
            tdo_d = DR_TDO;
        end
    end

    // Falling-edge stage keeps strobes stable across the DR cells' rising edge.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_q_q       <= '1;
            shift_dr_q   <= 1'b0;
            capture_dr_q <= 1'b0;
            update_dr_q  <= 1'b0;
            clk_en_q     <= 1'b0;
            tdo_q        <= 1'b0;
            tdo_en_q     <= 1'b0;
        end else begin
            ir_q_q       <= ir_q_d;
            shift_dr_q   <= shift_dr_d;
            capture_dr_q <= capture_dr_d;
            update_dr_q  <= update_dr_d;
            clk_en_q     <= clk_en_d;
            tdo_q        <= tdo_d;
            tdo_en_q     <= tdo_en_d;
        end
    end

    always_comb begin
        mode    = 1'b0;
        mux_sel = 1'b0;
        unique case (1'b1)
            (ir_q_q == IrExtest): begin
                mode    = 1'b1;
                mux_sel = 1'b1;
            end
            (ir_q_q == IrSample): begin
                mux_sel = 1'b1;
            end
            default: begin
                mode    = 1'b0;
                mux_sel = 1'b0;
            end
        endcase
    end

    // Enable only changes while TCK is low, so the AND cannot glitch.
    assign ClockDR     = TCK & clk_en_q;
    assign ShiftDR     = shift_dr_q;
    assign CaptureDR   = capture_dr_q;
    assign UpdateDR    = update_dr_q;
    assign TDO         = tdo_q;
    assign TDO_EN      = tdo_en_q;
    assign Mode        = mode;
    assign MUX_OUT_SEL = mux_sel;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Randomized bench for jtag_tap_controller against a table-driven TAP model.
// Directed scans pin the model with literal expectations.
module tb_jtag_tap_controller;
    import jtag_pkg::*;

    logic TCK, TRST, TMS, TDI, DR_TDO;
    logic ShiftDR, CaptureDR, ClockDR, UpdateDR;
    logic Mode, MUX_OUT_SEL, TDO, TDO_EN;
    bit   clk_run;
    logic last_dr;

    int total = 0;
    int bad   = 0;
    int n_clk = 0;

    jtag_tap_controller #(.IR_WIDTH(2)) u_dut (
        .TCK         (TCK),
        .TRST        (TRST),
        .TMS         (TMS),
        .TDI         (TDI),
        .DR_TDO      (DR_TDO),
        .ShiftDR     (ShiftDR),
        .CaptureDR   (CaptureDR),
        .ClockDR     (ClockDR),
        .UpdateDR    (UpdateDR),
        .Mode        (Mode),
        .MUX_OUT_SEL (MUX_OUT_SEL),
        .TDO         (TDO),
        .TDO_EN      (TDO_EN)
    );

    // Model state indices, in the order of the standard's state list.
    localparam int M_TLR = 0, M_CAPDR = 3, M_SHDR = 4, M_UPDDR = 8;
    localparam int M_CAPIR = 10, M_SHIR = 11, M_UPDIR = 15;

    int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    tap_state_t enc [16] = '{TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR,
                             PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR,
                             EX1_IR, PA_IR, EX2_IR, UPD_IR};

    int m_state = 0, m_ir_sh = 0, m_ir_q = 3;
    int m_sh = 0, m_cap = 0, m_upd = 0, m_clken = 0, m_tdo = 0, m_tdo_en = 0;

    initial TCK = 1'b0;
    always begin
        #5;
        if (clk_run) TCK = ~TCK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    always @(posedge ClockDR) n_clk++;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            m_state = M_TLR;
            m_ir_sh = 0;
        end else begin
            if (m_state == M_CAPIR) m_ir_sh = 1;
            else if (m_state == M_SHIR) m_ir_sh = (m_ir_sh >> 1) | (int'(TDI) << 1);
            m_state = TMS ? nx1[m_state] : nx0[m_state];
        end
    end

    always @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            m_sh = 0; m_cap = 0; m_upd = 0; m_clken = 0;
            m_tdo = 0; m_tdo_en = 0; m_ir_q = 3;
        end else begin
            m_sh     = int'(m_state == M_SHDR);
            m_cap    = int'(m_state == M_CAPDR);
            m_upd    = int'(m_state == M_UPDDR);
            m_clken  = int'(m_state == M_CAPDR || m_state == M_SHDR);
            m_tdo_en = int'(m_state == M_SHDR || m_state == M_SHIR);
            if (m_state == M_SHIR) m_tdo = m_ir_sh & 1;
            else if (m_state == M_SHDR) m_tdo = int'(DR_TDO);
            if (m_state == M_TLR) m_ir_q = 3;
            else if (m_state == M_UPDIR) m_ir_q = m_ir_sh;
        end
    end

    always @(negedge TCK) begin
        #1;
        if (TRST) begin
            check("ShiftDR", 32'(ShiftDR), 32'(m_sh));
            check("CaptureDR", 32'(CaptureDR), 32'(m_cap));
            check("UpdateDR", 32'(UpdateDR), 32'(m_upd));
            check("TDO", 32'(TDO), 32'(m_tdo));
            check("TDO_EN", 32'(TDO_EN), 32'(m_tdo_en));
            check("Mode", 32'(Mode), 32'(m_ir_q == 0));
            check("MUX_OUT_SEL", 32'(MUX_OUT_SEL), 32'(m_ir_q <= 1));
            check("ClockDR_low", 32'(ClockDR), 32'd0);
            check("state_fall", 32'(u_dut.state), 32'(enc[m_state]));
            check("ir_q", 32'(u_dut.ir_q_q), 32'(m_ir_q));
        end
    end

    always @(posedge TCK) begin
        #1;
        if (TRST) begin
            check("ClockDR_high", 32'(ClockDR), 32'(m_clken));
            check("state_rise", 32'(u_dut.state), 32'(enc[m_state]));
        end
    end

    task automatic tck(input logic tms, input logic tdi);
        TMS    = tms;
        TDI    = tdi;
        DR_TDO = 1'($urandom);
        last_dr = DR_TDO;
        @(posedge TCK);
        @(negedge TCK);
        #2;
    endtask

    // From RTI: load code (LSB first) and return to RTI.
    task automatic ir_scan(input logic [1:0] code);
        tck(1, 0);
        tck(1, 0);
        tck(0, 0);
        tck(0, 0);
        check("ir_tdo_first", 32'(TDO), 32'd1);
        tck(0, code[0]);
        check("ir_tdo_second", 32'(TDO), 32'd0);
        tck(1, code[1]);
        tck(1, 0);
        check("ir_mode_lit", 32'(Mode), 32'(code == 2'b00));
        check("ir_sel_lit", 32'(MUX_OUT_SEL), 32'(code == 2'b00 || code == 2'b01));
        tck(0, 0);
    endtask

    initial begin
        bit drseq [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int n_sh, n_up, n_en;
        TRST = 1'b1; TMS = 1'b1; TDI = 1'b0; DR_TDO = 1'b0;
        clk_run = 1'b0;
        #3 TRST = 1'b0;
        #2;
        check("rst_state", 32'(u_dut.state), 32'(TLR));
        check("rst_ir_q", 32'(u_dut.ir_q_q), 32'd3);
        check("rst_ir_sh", 32'(u_dut.ir_sh_q), 32'd0);
        check("rst_outs", {24'd0, ShiftDR, CaptureDR, ClockDR, UpdateDR,
                           Mode, MUX_OUT_SEL, TDO, TDO_EN}, 32'd0);
        #5 TRST = 1'b1;
        #2 clk_run = 1'b1;

        repeat (3) tck(1, 0);
        tck(0, 0);
        ir_scan(2'b00);
        check("extest_mode", 32'(Mode), 32'd1);
        ir_scan(2'b01);

        n_clk = 0; n_sh = 0; n_up = 0;
        for (int i = 0; i < 8; i++) begin
            tck(drseq[i], 0);
            n_sh += int'(ShiftDR);
            n_up += int'(UpdateDR);
            if (i == 2) check("dr_tdo_follow", 32'(TDO), 32'(last_dr));
        end
        check("dr_clk_pulses", 32'(n_clk), 32'd4);
        check("dr_shift_cycles", 32'(n_sh), 32'd3);
        check("dr_update_pulses", 32'(n_up), 32'd1);

        tck(1, 0); tck(0, 0); tck(0, 0);
        repeat (5) tck(1, 0);
        check("five_tms_state", 32'(u_dut.state), 32'(TLR));
        check("five_tms_ir_q", 32'(u_dut.ir_q_q), 32'd3);
        tck(0, 0);

        tck(1, 0); tck(0, 0); tck(1, 0);
        n_clk = 0; n_en = 0;
        repeat (4) begin
            tck(0, 0);
            n_en += int'(TDO_EN);
        end
        check("pause_clk_pulses", 32'(n_clk), 32'd0);
        check("pause_tdo_en", 32'(n_en), 32'd0);
        tck(1, 0); tck(1, 0); tck(0, 0);

        ir_scan(2'b00);
        tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
        tck(0, 1); tck(0, 1);
        TRST = 1'b0;
        #1;
        check("trst_state", 32'(u_dut.state), 32'(TLR));
        check("trst_ir_q", 32'(u_dut.ir_q_q), 32'd3);
        check("trst_mode", 32'(Mode), 32'd0);
        check("trst_sel", 32'(MUX_OUT_SEL), 32'd0);
        check("trst_tdo_en", 32'(TDO_EN), 32'd0);
        #1 TRST = 1'b1;
        tck(1, 0); tck(0, 0);
        check("post_trst_ir_q", 32'(u_dut.ir_q_q), 32'd3);

        repeat (600) tck(1'($urandom_range(0, 2) == 0), 1'($urandom));
        repeat (5) tck(1, 0);
        check("final_state", 32'(u_dut.state), 32'(TLR));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
